mfb_pkt_arbiter: RTL and testbench
==================================

MFB_PKT_ARBITER -- requirements
Module: mfb_pkt_arbiter

Interface
REQ-001 Parameter INPUTS, default 2: number of MFB requesters (2..8).
REQ-002 Parameter REGION_SIZE, default 8: blocks per region; bus has one region.
REQ-003 Parameter BLOCK_SIZE, default 8: items per block.
REQ-004 Parameter ITEM_WIDTH, default 8: bits per item.
REQ-005 Parameter META_WIDTH, default 1: metadata bits per region, valid with SOF.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 CLK  in  1  clock; all state on rising edge.
REQ-008 RESET_N  in  1  asynchronous active-low reset.
REQ-009 RX_DATA  in  INPUTS x REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH  per-input word.
REQ-010 RX_META  in  INPUTS x META_WIDTH  per-input metadata.
REQ-011 RX_SOF, RX_EOF  in  INPUTS x 1  start/end of packet in word.
REQ-012 RX_SOF_POS  in  INPUTS x clog2(REGION_SIZE)  SOF block index.
REQ-013 RX_EOF_POS  in  INPUTS x clog2(REGION_SIZE*BLOCK_SIZE)  EOF item index.
REQ-014 RX_SRC_RDY  in  INPUTS x 1 word valid; RX_DST_RDY  out  INPUTS x 1 accept.
REQ-015 TX_DATA, TX_META, TX_SOF, TX_EOF, TX_SOF_POS, TX_EOF_POS  out  single-input widths  merged stream.
REQ-016 TX_SRC_RDY  out  1; TX_DST_RDY  in  1; TX_SEL  out  clog2(INPUTS)  source input of TX word.

Function
REQ-017 Transfer on a port occurs when SRC_RDY and DST_RDY are both 1 on a rising edge.
REQ-018 Output is one register stage; accepted RX word appears on TX on the next cycle; latency 1.
REQ-019 Output stage loads when TX_SRC_RDY=0 or TX_DST_RDY=1 (load enable, LE); otherwise TX holds all fields.
REQ-020 FSM states IDLE and LOCKED; state register LOCK_IDX holds granted input.
REQ-021 IDLE: candidate set = inputs with RX_SRC_RDY=1 and RX_SOF=1; winner = first candidate at or after RR_PTR, wrapping modulo INPUTS.
REQ-022 IDLE with candidate and LE=1: RX_DST_RDY(winner)=1 the same cycle (combinational grant), word transferred.
REQ-023 IDLE -> LOCKED when the granted word has SOF without terminating EOF (EOF absent, or EOF present with SOF_POS*BLOCK_SIZE > EOF_POS i.e. trailing new packet).
REQ-024 IDLE stays IDLE when granted word holds a complete packet (SOF and EOF, SOF_POS*BLOCK_SIZE <= EOF_POS, no trailing SOF).
REQ-025 LOCKED: only RX_DST_RDY(LOCK_IDX) may be 1, equal to LE; other inputs see 0.
REQ-026 LOCKED -> IDLE on transfer of a word with EOF=1 and no trailing SOF (SOF=0 or SOF_POS*BLOCK_SIZE <= EOF_POS).
REQ-027 Word with EOF plus trailing SOF keeps LOCKED on same input (packet boundary inside word cannot be split).
REQ-028 On every IDLE/LOCKED -> IDLE return, RR_PTR := (granted index + 1) mod INPUTS; otherwise RR_PTR holds.
REQ-029 In IDLE, inputs with RX_SRC_RDY=1 and RX_SOF=0 are not granted (protocol violation; held, never dropped).
REQ-030 Simultaneous requests from all inputs: grants rotate one packet per input in index order from RR_PTR.
REQ-031 TX_SEL = index of input whose word is on TX; TX_META is copied unchanged from the same input.
REQ-032 No combinational path from RX_* to TX_*; TX_DST_RDY to RX_DST_RDY is combinational through LE.

Reset
REQ-033 RESET_N=0 asynchronously sets: state IDLE, RR_PTR 0, LOCK_IDX 0, TX_SRC_RDY 0, TX_SOF 0, TX_EOF 0, TX_SEL 0.
REQ-034 TX_DATA, TX_META, TX_SOF_POS, TX_EOF_POS need no reset; value undefined while TX_SRC_RDY=0.
REQ-035 Reset asserted mid-packet discards the lock; after release arbitration restarts in IDLE at input 0.
REQ-036 During reset all RX_DST_RDY = 0.

Structure
REQ-037 Package mfb_pkt_arbiter_pkg holds the state enum (IDLE, LOCKED) and the functions computing index widths and the "packet ends in word" / "trailing SOF" predicates.
REQ-038 One sub-module mfb_rr_select: INPUTS-bit request vector plus pointer -> one-hot grant and index, purely combinational.

Verification
REQ-039 INPUTS=2, both idle-requesting single-word packets, TX_DST_RDY=1 -> TX_SEL sequence 0,1,0,1; one word per cycle; latency 1.
REQ-040 Input 0 sends 3-word packet, input 1 requests from cycle 1 -> input 1 RX_DST_RDY=0 for 3 cycles, then granted; TX_SEL 0,0,0,1.
REQ-041 Input 0 word EOF_POS=10, SOF_POS=2 (trailing SOF), next word EOF -> grant stays on 0 for both words; input 1 waits.
REQ-042 TX_DST_RDY=0 for 4 cycles mid-packet -> TX fields stable, no RX transfer, no loss or duplication in scoreboard.
REQ-043 RESET_N pulsed low while LOCKED on input 1 -> TX_SRC_RDY=0 immediately; after release first grant follows RR_PTR=0.
REQ-044 INPUTS=4, all inputs always requesting, random lengths 1..16 words -> each input granted once per 4 packets, all mfb protocol properties hold.

Source files
------------

// File: rtl/mfb_pkt_arbiter_pkg.sv
// Shared types and helpers for the MFB packet arbiter.
package mfb_pkt_arbiter_pkg;

    // Arbiter state: free to pick a new packet, or bound to one input until its EOF.
    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    // Width of an index into n entries; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The open packet finishes in this word and no new packet starts after its EOF.
    function automatic logic word_ends_pkt(
        input logic        sof,
        input logic        eof,
        input int unsigned sof_pos,
        input int unsigned eof_pos,
        input int unsigned block_size
    );
        return eof && (!sof || (sof_pos * block_size <= eof_pos));
    endfunction

    // A packet starts in this word and is still open when the word ends.
    function automatic logic trailing_sof(
        input logic        sof,
        input logic        eof,
        input int unsigned sof_pos,
        input int unsigned eof_pos,
        input int unsigned block_size
    );
        return sof && (!eof || (sof_pos * block_size > eof_pos));
    endfunction

endpackage

// File: rtl/mfb_rr_select.sv
// Round-robin pick: first set request at or after ptr, wrapping. Purely combinational.
module mfb_rr_select
    import mfb_pkt_arbiter_pkg::*;
#(
    parameter int unsigned INPUTS = 2,
    localparam int unsigned SelW  = idx_width(INPUTS)
) (
    input  logic [INPUTS-1:0] req,
    input  logic [SelW-1:0]   ptr,
    output logic [INPUTS-1:0] gnt,
    output logic [SelW-1:0]   idx,
    output logic              valid
);

    logic [SelW-1:0] scan_idx;

    // Walk the inputs starting at ptr and keep the first requester found.
    always_comb begin
        gnt      = '0;
        idx      = '0;
        valid    = 1'b0;
        scan_idx = '0;
        for (int unsigned k = 0; k < INPUTS; k++) begin
            scan_idx = SelW'((32'(ptr) + k) % INPUTS);
            if (!valid && req[scan_idx]) begin
                valid         = 1'b1;
                gnt[scan_idx] = 1'b1;
                idx           = scan_idx;
            end
        end
    end

endmodule

// File: rtl/mfb_pkt_arbiter.sv
// Packet-granular round-robin merge of several single-region MFB streams into one,
// behind a single output register stage.
module mfb_pkt_arbiter
    import mfb_pkt_arbiter_pkg::*;
#(
    parameter int unsigned INPUTS      = 2,
    parameter int unsigned REGION_SIZE = 8,
    parameter int unsigned BLOCK_SIZE  = 8,
    parameter int unsigned ITEM_WIDTH  = 8,
    parameter int unsigned META_WIDTH  = 1,
    localparam int unsigned DataW      = REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH,
    localparam int unsigned SofPosW    = idx_width(REGION_SIZE),
    localparam int unsigned EofPosW    = idx_width(REGION_SIZE * BLOCK_SIZE),
    localparam int unsigned SelW       = idx_width(INPUTS)
) (
    input  logic                               clk,
    input  logic                               reset_n,

    input  logic [INPUTS-1:0][DataW-1:0]       rx_data,
    input  logic [INPUTS-1:0][META_WIDTH-1:0]  rx_meta,
    input  logic [INPUTS-1:0]                  rx_sof,
    input  logic [INPUTS-1:0]                  rx_eof,
    input  logic [INPUTS-1:0][SofPosW-1:0]     rx_sof_pos,
    input  logic [INPUTS-1:0][EofPosW-1:0]     rx_eof_pos,
    input  logic [INPUTS-1:0]                  rx_src_rdy,
    output logic [INPUTS-1:0]                  rx_dst_rdy,

    output logic [DataW-1:0]                   tx_data,
    output logic [META_WIDTH-1:0]              tx_meta,
    output logic                               tx_sof,
    output logic                               tx_eof,
    output logic [SofPosW-1:0]                 tx_sof_pos,
    output logic [EofPosW-1:0]                 tx_eof_pos,
    output logic                               tx_src_rdy,
    input  logic                               tx_dst_rdy,
    output logic [SelW-1:0]                    tx_sel
);

    state_e              state_q;
    logic [SelW-1:0]     rr_ptr_q;
    logic [SelW-1:0]     lock_idx_q;

    logic                tx_src_rdy_q;
    logic                tx_sof_q;
    logic                tx_eof_q;
    logic [SelW-1:0]     tx_sel_q;
    logic [DataW-1:0]    tx_data_q;
    logic [META_WIDTH-1:0] tx_meta_q;
    logic [SofPosW-1:0]  tx_sof_pos_q;
    logic [EofPosW-1:0]  tx_eof_pos_q;

    logic                le;
    logic [INPUTS-1:0]   cand;
    logic [INPUTS-1:0]   win_gnt;
    logic [SelW-1:0]     win_idx;
    logic                win_valid;
    logic [SelW-1:0]     sel_idx;
    logic                xfer;
    logic                sel_sof;
    logic                sel_eof;
    logic                sel_ends;
    logic                sel_trail;

    function automatic logic [SelW-1:0] ptr_after(input logic [SelW-1:0] idx);
        return (32'(idx) + 1 >= INPUTS) ? '0 : idx + 1'b1;
    endfunction

    // Output register can take a new word when empty or being drained.
    assign le   = !tx_src_rdy_q || tx_dst_rdy;
    // Only a word carrying SOF may open a new grant.
    assign cand = rx_src_rdy & rx_sof;

    mfb_rr_select #(
        .INPUTS (INPUTS)
    ) u_rr_select (
        .req   (cand),
        .ptr   (rr_ptr_q),
        .gnt   (win_gnt),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // Grant decode: round-robin winner when idle, the locked input otherwise.
    always_comb begin
        rx_dst_rdy = '0;
        xfer       = 1'b0;
        sel_idx    = lock_idx_q;
        if (state_q == StIdle) begin
            sel_idx = win_idx;
            if (win_valid && le) begin
                rx_dst_rdy = win_gnt;
                xfer       = 1'b1;
            end
        end else begin
            rx_dst_rdy[lock_idx_q] = le;
            xfer                   = le && rx_src_rdy[lock_idx_q];
        end
        // Nothing is accepted while reset is held.
        if (!reset_n) begin
            rx_dst_rdy = '0;
            xfer       = 1'b0;
        end
    end

    assign sel_sof   = rx_sof[sel_idx];
    assign sel_eof   = rx_eof[sel_idx];
    assign sel_ends  = word_ends_pkt(sel_sof, sel_eof, 32'(rx_sof_pos[sel_idx]),
                                     32'(rx_eof_pos[sel_idx]), BLOCK_SIZE);
    assign sel_trail = trailing_sof(sel_sof, sel_eof, 32'(rx_sof_pos[sel_idx]),
                                    32'(rx_eof_pos[sel_idx]), BLOCK_SIZE);

    // Arbitration FSM plus the reset-carrying output control fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            lock_idx_q   <= '0;
            tx_src_rdy_q <= 1'b0;
            tx_sof_q     <= 1'b0;
            tx_eof_q     <= 1'b0;
            tx_sel_q     <= '0;
        end else begin
            if (le) begin
                tx_src_rdy_q <= xfer;
                if (xfer) begin
                    tx_sof_q <= sel_sof;
                    tx_eof_q <= sel_eof;
                    tx_sel_q <= sel_idx;
                end
            end
            if (xfer) begin
                unique case (state_q)
                    StIdle: begin
                        if (sel_trail) begin
                            state_q    <= StLocked;
                            lock_idx_q <= sel_idx;
                        end else begin
                            rr_ptr_q <= ptr_after(sel_idx);
                        end
                    end
                    StLocked: begin
                        if (sel_ends) begin
                            state_q  <= StIdle;
                            rr_ptr_q <= ptr_after(sel_idx);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Payload fields are only meaningful while tx_src_rdy is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            tx_data_q    <= rx_data[sel_idx];
            tx_meta_q    <= rx_meta[sel_idx];
            tx_sof_pos_q <= rx_sof_pos[sel_idx];
            tx_eof_pos_q <= rx_eof_pos[sel_idx];
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_meta    = tx_meta_q;
    assign tx_sof     = tx_sof_q;
    assign tx_eof     = tx_eof_q;
    assign tx_sof_pos = tx_sof_pos_q;
    assign tx_eof_pos = tx_eof_pos_q;
    assign tx_src_rdy = tx_src_rdy_q;
    assign tx_sel     = tx_sel_q;

endmodule

// File: tb/tb_mfb_pkt_arbiter.sv
// Randomized and directed bench for mfb_pkt_arbiter against a queue-based reference model.
module tb_mfb_pkt_arbiter;

    localparam int NIN = 4;
    localparam int RS  = 8;
    localparam int BS  = 8;
    localparam int IW  = 1;
    localparam int MW  = 4;
    localparam int DW  = RS * BS * IW;
    localparam int SPW = 3;
    localparam int EPW = 6;
    localparam int SW  = 2;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [MW-1:0]  meta;
        logic           sof;
        logic           eof;
        logic [SPW-1:0] sof_pos;
        logic [EPW-1:0] eof_pos;
    } word_t;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [NIN-1:0][DW-1:0]   rx_data = '0;
    logic [NIN-1:0][MW-1:0]   rx_meta = '0;
    logic [NIN-1:0]           rx_sof = '0;
    logic [NIN-1:0]           rx_eof = '0;
    logic [NIN-1:0][SPW-1:0]  rx_sof_pos = '0;
    logic [NIN-1:0][EPW-1:0]  rx_eof_pos = '0;
    logic [NIN-1:0]           rx_src_rdy = '0;
    logic [NIN-1:0]           rx_dst_rdy;
    logic [DW-1:0]            tx_data;
    logic [MW-1:0]            tx_meta;
    logic                     tx_sof;
    logic                     tx_eof;
    logic [SPW-1:0]           tx_sof_pos;
    logic [EPW-1:0]           tx_eof_pos;
    logic                     tx_src_rdy;
    logic                     tx_dst_rdy = 1'b0;
    logic [SW-1:0]            tx_sel;

    mfb_pkt_arbiter #(
        .INPUTS      (NIN),
        .REGION_SIZE (RS),
        .BLOCK_SIZE  (BS),
        .ITEM_WIDTH  (IW),
        .META_WIDTH  (MW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_meta    (rx_meta),
        .rx_sof     (rx_sof),
        .rx_eof     (rx_eof),
        .rx_sof_pos (rx_sof_pos),
        .rx_eof_pos (rx_eof_pos),
        .rx_src_rdy (rx_src_rdy),
        .rx_dst_rdy (rx_dst_rdy),
        .tx_data    (tx_data),
        .tx_meta    (tx_meta),
        .tx_sof     (tx_sof),
        .tx_eof     (tx_eof),
        .tx_sof_pos (tx_sof_pos),
        .tx_eof_pos (tx_eof_pos),
        .tx_src_rdy (tx_src_rdy),
        .tx_dst_rdy (tx_dst_rdy),
        .tx_sel     (tx_sel)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Per-input source queues and start cycles.
    word_t srcq [NIN][$];
    int    start_cyc [NIN];
    int    cyc;
    int    dst_mode;
    int    stall_lo;
    int    stall_hi;

    // Reference model: owner (-1 when free), round-robin pointer, output register.
    int    m_owner;
    int    m_ptr;
    logic  m_tv;
    word_t m_tw;
    int    m_tsel;

    // Observations of the DUT output stream.
    int    sel_log [$];
    int    cyc_log [$];
    int    sof_log [$];
    int    wait1;
    int    stall_rx;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic word_t mk(input logic sof, input logic eof, input int sp, input int ep);
        word_t w;
        w.data    = {$urandom, $urandom};
        w.meta    = MW'($urandom);
        w.sof     = sof;
        w.eof     = eof;
        w.sof_pos = SPW'(sp);
        w.eof_pos = EPW'(ep);
        return w;
    endfunction

    // Well-formed packet of len words; a single-word packet keeps EOF at or after SOF.
    task automatic push_pkt(input int i, input int len);
        int sp;
        sp = int'($urandom_range(0, 7));
        if (len == 1) begin
            srcq[i].push_back(mk(1'b1, 1'b1, sp, int'($urandom_range(sp * 8, 63))));
        end else begin
            srcq[i].push_back(mk(1'b1, 1'b0, sp, int'($urandom_range(0, 63))));
            for (int k = 1; k < len - 1; k++)
                srcq[i].push_back(mk(1'b0, 1'b0, int'($urandom_range(0, 7)),
                                     int'($urandom_range(0, 63))));
            srcq[i].push_back(mk(1'b0, 1'b1, int'($urandom_range(0, 7)),
                                 int'($urandom_range(0, 63))));
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_ptr    = 0;
        m_tv     = 1'b0;
        m_tsel   = 0;
        m_tw     = '0;
        cyc      = 0;
        dst_mode = 0;
        wait1    = 0;
        stall_rx = 0;
        for (int i = 0; i < NIN; i++) begin
            srcq[i].delete();
            start_cyc[i] = 0;
        end
        sel_log.delete();
        cyc_log.delete();
        sof_log.delete();
    endtask

    function automatic int queued();
        int n = 0;
        for (int i = 0; i < NIN; i++) n += srcq[i].size();
        return n;
    endfunction

    task automatic drive_inputs();
        word_t w;
        for (int i = 0; i < NIN; i++) begin
            if (srcq[i].size() > 0 && cyc >= start_cyc[i]) begin
                w = srcq[i][0];
                rx_src_rdy[i] = 1'b1;
                rx_data[i]    = w.data;
                rx_meta[i]    = w.meta;
                rx_sof[i]     = w.sof;
                rx_eof[i]     = w.eof;
                rx_sof_pos[i] = w.sof_pos;
                rx_eof_pos[i] = w.eof_pos;
            end else begin
                rx_src_rdy[i] = 1'b0;
                rx_sof[i]     = 1'b0;
                rx_eof[i]     = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive, check grants, clock, update model, check TX.
    task automatic step();
        int       w;
        int       j;
        logic     le;
        logic [NIN-1:0] exp_dst;
        word_t    cw;
        word_t    dutw;
        @(negedge clk);
        drive_inputs();
        case (dst_mode)
            1:       tx_dst_rdy = ($urandom_range(0, 99) < 70);
            2:       tx_dst_rdy = !(cyc >= stall_lo && cyc < stall_hi);
            default: tx_dst_rdy = 1'b1;
        endcase
        #1;
        le = !m_tv || tx_dst_rdy;
        w  = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < NIN; k++) begin
                j = (m_ptr + k) % NIN;
                if (w < 0 && rx_src_rdy[j] && rx_sof[j]) w = j;
            end
        end else if (rx_src_rdy[m_owner]) begin
            w = m_owner;
        end
        exp_dst = '0;
        if (le) begin
            if (m_owner >= 0) exp_dst[m_owner] = 1'b1;
            else if (w >= 0) exp_dst[w] = 1'b1;
        end
        check_eq("rx_dst_rdy", rx_dst_rdy, exp_dst);
        if (rx_src_rdy[1] && !rx_dst_rdy[1]) wait1++;
        if (dst_mode == 2 && !tx_dst_rdy && |(rx_src_rdy & rx_dst_rdy)) stall_rx++;
        if (tx_src_rdy && tx_dst_rdy) begin
            sel_log.push_back(int'(tx_sel));
            cyc_log.push_back(cyc);
            if (tx_sof) sof_log.push_back(int'(tx_sel));
        end
        if (!le) w = -1;
        @(posedge clk);
        #1;
        if (le) begin
            m_tv = (w >= 0);
            if (w >= 0) begin
                cw     = srcq[w].pop_front();
                m_tw   = cw;
                m_tsel = w;
                if (m_owner < 0) begin
                    if (cw.sof && (!cw.eof || int'(cw.sof_pos) * BS > int'(cw.eof_pos)))
                        m_owner = w;
                    else
                        m_ptr = (w + 1) % NIN;
                end else if (cw.eof && !(cw.sof && int'(cw.sof_pos) * BS > int'(cw.eof_pos))) begin
                    m_owner = -1;
                    m_ptr   = (w + 1) % NIN;
                end
            end
        end
        check_eq("tx_src_rdy", tx_src_rdy, m_tv);
        if (m_tv) begin
            dutw.data    = tx_data;
            dutw.meta    = tx_meta;
            dutw.sof     = tx_sof;
            dutw.eof     = tx_eof;
            dutw.sof_pos = tx_sof_pos;
            dutw.eof_pos = tx_eof_pos;
            check_eq("tx_word", dutw, m_tw);
            check_eq("tx_sel", tx_sel, m_tsel);
        end
        cyc++;
    endtask

    task automatic run(input int max_cyc);
        int n = 0;
        while ((queued() > 0 || m_tv) && n < max_cyc) begin
            step();
            n++;
        end
        check_eq("drain_timeout", (queued() > 0 || m_tv), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        rx_src_rdy = '0;
        tx_dst_rdy = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq("rst_tx_src_rdy", tx_src_rdy, 0);
        check_eq("rst_tx_sof_eof", {tx_sof, tx_eof}, 0);
        check_eq("rst_tx_sel", tx_sel, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic int at(input int q [$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    int total;

    initial begin
        model_reset();

        // Two inputs with single-word packets alternate, one word per cycle.
        do_reset();
        push_pkt(0, 1); push_pkt(0, 1);
        push_pkt(1, 1); push_pkt(1, 1);
        run(50);
        check_eq("alt_count", sel_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check_eq("alt_sel", at(sel_log, k), k % 2);
            check_eq("alt_cycle", at(cyc_log, k), k + 1);
        end

        // A 3-word packet holds off the other requester.
        do_reset();
        push_pkt(0, 3);
        push_pkt(1, 1);
        run(50);
        check_eq("lock_count", sel_log.size(), 4);
        for (int k = 0; k < 4; k++) check_eq("lock_sel", at(sel_log, k), (k < 3) ? 0 : 1);
        check_eq("lock_wait1", wait1, 3);

        // EOF followed by a trailing SOF in the same word keeps the lock.
        do_reset();
        srcq[0].push_back(mk(1'b1, 1'b1, 2, 10));
        srcq[0].push_back(mk(1'b0, 1'b1, 0, 5));
        push_pkt(1, 1);
        run(50);
        check_eq("trail_count", sel_log.size(), 3);
        for (int k = 0; k < 3; k++) check_eq("trail_sel", at(sel_log, k), (k < 2) ? 0 : 1);
        check_eq("trail_wait1", wait1, 2);

        // Output back-pressure mid-packet.
        do_reset();
        dst_mode = 2;
        stall_lo = 2;
        stall_hi = 6;
        push_pkt(0, 4);
        run(50);
        check_eq("stall_count", sel_log.size(), 4);
        check_eq("stall_rx_xfers", stall_rx, 0);

        // A word without SOF is never granted while idle.
        do_reset();
        srcq[2].push_back(mk(1'b0, 1'b0, 0, 0));
        repeat (4) step();
        check_eq("nosof_count", sel_log.size(), 0);
        check_eq("nosof_held", srcq[2].size(), 1);

        // Reset while locked on input 1 after the pointer has moved to 1.
        do_reset();
        push_pkt(0, 1);
        push_pkt(1, 5);
        repeat (4) step();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_tx_src_rdy", tx_src_rdy, 0);
        check_eq("async_rst_rx_dst_rdy", rx_dst_rdy, 0);
        model_reset();
        rx_src_rdy = '0;
        @(negedge clk);
        reset_n = 1'b1;
        push_pkt(0, 1);
        push_pkt(1, 1);
        run(50);
        check_eq("post_rst_first", at(sel_log, 0), 0);
        check_eq("post_rst_second", at(sel_log, 1), 1);

        // All four inputs always requesting, random lengths, random back-pressure.
        do_reset();
        for (int i = 0; i < NIN; i++)
            repeat (5) push_pkt(i, int'($urandom_range(1, 16)));
        total = queued();
        dst_mode = 1;
        run(3000);
        check_eq("rr_words", sel_log.size(), total);
        check_eq("rr_pkts", sof_log.size(), 5 * NIN);
        for (int k = 0; k < 5 * NIN; k++) check_eq("rr_order", at(sof_log, k), k % NIN);

        // Sparse requests with random start times.
        do_reset();
        for (int i = 0; i < NIN; i++) begin
            start_cyc[i] = int'($urandom_range(0, 30));
            repeat (3) push_pkt(i, int'($urandom_range(1, 8)));
        end
        total = queued();
        dst_mode = 1;
        run(2000);
        check_eq("sparse_words", sel_log.size(), total);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
